// File: rtl/proc_io_pkg.sv
// proc_io_pkg: shared types and defaults for the processor input path.
package proc_io_pkg;
    localparam int DW_DEF  = 16;
    localparam int AW_DEF  = 7;
    localparam int STALL_W = 16;
    typedef enum logic [1:0] {IDLE, ARMED, STREAM, DONE} feeder_state_t;
endpackage

// File: rtl/fifo_sample_feeder.sv
// fifo_sample_feeder: paces valid/ready samples into the processor input FIFO, one frame per req.
module fifo_sample_feeder
    import proc_io_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int AW        = AW_DEF,
    parameter int FRAME_LEN = 64,
    parameter int PACE      = 4,
    parameter int HIGH_WM   = 124
) (
    input  logic               clk,
    input  logic               rst_geral_n,
    input  logic               en,
    input  logic [DW-1:0]      s_data,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic               req,
    input  logic               fifo_full,
    input  logic [AW-1:0]      fifo_usedw,
    output logic [DW-1:0]      fifo_data,
    output logic               fifo_wrreq,
    output logic               busy,
    output logic               frame_done,
    output logic [STALL_W-1:0] stall_cnt
);
    localparam int FW = $clog2(FRAME_LEN + 1);
    localparam int PW = PACE > 1 ? $clog2(PACE) : 1;

    feeder_state_t state, state_nxt;
    logic          pend;
    logic [FW-1:0] frame_cnt;
    logic [PW-1:0] pace_cnt;
    logic          wr_ok, last_wr;

    assign wr_ok   = state == STREAM && en && s_valid && pace_cnt == '0 && !fifo_full
                     && int'(fifo_usedw) < HIGH_WM;
    assign last_wr = wr_ok && frame_cnt == FW'(FRAME_LEN - 1);

    always_ff @(posedge clk or negedge rst_geral_n) begin
        if (!rst_geral_n) state <= IDLE;
        else              state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = en ? ARMED : IDLE;
            ARMED:   state_nxt = !en ? IDLE : req ? STREAM : ARMED;
            STREAM:  state_nxt = !en ? IDLE : last_wr ? DONE : STREAM;
            DONE:    state_nxt = !en ? IDLE : (pend || req) ? STREAM : ARMED;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_ready    = wr_ok;
        busy       = state == STREAM;
        frame_done = state == DONE;
    end

    // Frame counter is zero whenever not streaming, so each STREAM entry starts a fresh frame.
    always_ff @(posedge clk or negedge rst_geral_n) begin
        if (!rst_geral_n) begin
            fifo_data  <= '0;
            fifo_wrreq <= 1'b0;
            pend       <= 1'b0;
            frame_cnt  <= '0;
            pace_cnt   <= '0;
        end else begin
            fifo_wrreq <= wr_ok;
            if (wr_ok) fifo_data <= s_data;
            pend       <= en && state == STREAM && (pend || req);
            frame_cnt  <= state_nxt != STREAM ? '0 : wr_ok ? frame_cnt + 1'b1 : frame_cnt;
            pace_cnt   <= wr_ok ? PW'(PACE - 1) : pace_cnt != '0 ? pace_cnt - 1'b1 : pace_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_geral_n) begin
        if (!rst_geral_n)
            stall_cnt <= '0;
        else if (state == STREAM && s_valid && pace_cnt == '0 && !wr_ok && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_fifo_sample_feeder.sv
// tb_fifo_sample_feeder: directed scoreboard bench for the FIFO sample feeder.
module tb_fifo_sample_feeder;
    logic               clk = 1'b0;
    logic               rst_geral_n = 1'b0;
    logic               en = 1'b0;
    logic signed [15:0] s_data = '0;
    logic               s_valid = 1'b0;
    logic               req = 1'b0;
    logic               fifo_full = 1'b0;
    logic [6:0]         fifo_usedw = '0;
    logic               s_ready, fifo_wrreq, busy, frame_done;
    logic [15:0]        fifo_data, stall_cnt;
    logic               s_ready4, wr4, busy4, done4;
    logic [15:0]        data4, stall4;

    int          errors = 0, checks = 0, cyc = 0, wr_cnt = 0, done_cnt = 0, n4 = 0;
    int          w4 [8];
    logic        prev_acc = 1'b0, ramp = 1'b1, rec4 = 1'b0;
    logic [15:0] sb [$];
    logic [15:0] exp_d;
    int          w0, d0, st0;

    always #5 clk = ~clk;

    fifo_sample_feeder #(.FRAME_LEN(4), .PACE(1)) u1 (
        .clk(clk), .rst_geral_n(rst_geral_n), .en(en), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .req(req), .fifo_full(fifo_full), .fifo_usedw(fifo_usedw),
        .fifo_data(fifo_data), .fifo_wrreq(fifo_wrreq), .busy(busy), .frame_done(frame_done),
        .stall_cnt(stall_cnt));

    fifo_sample_feeder #(.FRAME_LEN(4), .PACE(4)) u4 (
        .clk(clk), .rst_geral_n(rst_geral_n), .en(en), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready4), .req(req), .fifo_full(fifo_full), .fifo_usedw(fifo_usedw),
        .fifo_data(data4), .fifo_wrreq(wr4), .busy(busy4), .frame_done(done4),
        .stall_cnt(stall4));

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            chk("wrreq_latency", 32'(fifo_wrreq), 32'(prev_acc));
            if (fifo_wrreq) begin
                wr_cnt++;
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_d = sb.pop_front();
                    chk("fifo_data", 32'(fifo_data), 32'(exp_d));
                end
            end
            if (frame_done) done_cnt++;
            if (rec4 && wr4) begin
                if (n4 < 8) w4[n4] = cyc;
                n4++;
                chk("pace4_data", 32'(data4), 32'h0000_D45C);
            end
            prev_acc = s_valid & s_ready;
            if (prev_acc) sb.push_back(s_data);
            @(posedge clk);
            #1;
            if (prev_acc && ramp) s_data = s_data + 16'sd1;
        end
    endtask

    task automatic pulse_req();
        req = 1'b1;
        step(1);
        req = 1'b0;
    endtask

    task automatic do_reset();
        rst_geral_n = 1'b0;
        prev_acc = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #3 rst_geral_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_wrreq", 32'(fifo_wrreq), 0);
        chk("rst_data", 32'(fifo_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_stall", 32'(stall_cnt), 0);
        do_reset();

        // back-to-back frame of 4 with PACE=1
        en = 1'b1;
        step(1);
        s_valid = 1'b1;
        s_data = 16'sd1;
        #1;
        chk("armed_ready", 32'(s_ready), 0);
        chk("armed_busy", 32'(busy), 0);
        w0 = wr_cnt; d0 = done_cnt;
        pulse_req();
        chk("stream_busy", 32'(busy), 1);
        step(5);
        chk("b2b_wr", 32'(wr_cnt - w0), 4);
        chk("b2b_done", 32'(done_cnt - d0), 1);
        step(3);
        chk("frame_end_wr", 32'(wr_cnt - w0), 4);
        chk("frame_end_done", 32'(done_cnt - d0), 1);
        chk("frame_sb", 32'(sb.size()), 0);

        // PACE=4 spacing and negative sample passthrough
        ramp = 1'b0;
        s_data = -16'sd11172;
        do_reset();
        step(1);
        rec4 = 1'b1;
        n4 = 0;
        pulse_req();
        step(20);
        rec4 = 1'b0;
        chk("pace4_count", 32'(n4), 4);
        chk("pace4_gap1", 32'(w4[1] - w4[0]), 4);
        chk("pace4_gap2", 32'(w4[2] - w4[1]), 4);
        chk("pace4_gap3", 32'(w4[3] - w4[2]), 4);
        chk("pace4_last_data", 32'(data4), 32'h0000_D45C);

        // high watermark throttling
        ramp = 1'b1;
        s_data = 16'sh0100;
        w0 = wr_cnt; d0 = done_cnt;
        pulse_req();
        step(1);
        fifo_usedw = 7'd124;
        #1;
        st0 = int'(stall_cnt);
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("wm_ready", 32'(s_ready), 0);
        end
        chk("wm_stall", 32'(stall_cnt), 32'(st0 + 10));
        chk("wm_inflight_wr", 32'(wr_cnt - w0), 1);
        fifo_usedw = 7'd100;
        step(8);
        chk("wm_wr", 32'(wr_cnt - w0), 4);
        chk("wm_done", 32'(done_cnt - d0), 1);
        chk("wm_sb", 32'(sb.size()), 0);

        // two reqs during STREAM collapse into one extra frame
        w0 = wr_cnt; d0 = done_cnt;
        pulse_req();
        step(1);
        pulse_req();
        step(1);
        pulse_req();
        step(20);
        chk("pend_wr", 32'(wr_cnt - w0), 8);
        chk("pend_done", 32'(done_cnt - d0), 2);
        chk("pend_busy", 32'(busy), 0);
        chk("pend_ready", 32'(s_ready), 0);

        // en drop abandons a partial frame
        w0 = wr_cnt; d0 = done_cnt;
        pulse_req();
        step(2);
        en = 1'b0;
        #1;
        chk("abort_ready", 32'(s_ready), 0);
        step(4);
        chk("abort_wr", 32'(wr_cnt - w0), 2);
        chk("abort_done", 32'(done_cnt - d0), 0);
        chk("abort_busy", 32'(busy), 0);
        en = 1'b1;
        step(1);
        w0 = wr_cnt; d0 = done_cnt;
        pulse_req();
        step(8);
        chk("refill_wr", 32'(wr_cnt - w0), 4);
        chk("refill_done", 32'(done_cnt - d0), 1);
        chk("refill_sb", 32'(sb.size()), 0);

        // asynchronous reset mid-stream
        pulse_req();
        step(2);
        rst_geral_n = 1'b0;
        #1;
        chk("arst_wrreq", 32'(fifo_wrreq), 0);
        chk("arst_data", 32'(fifo_data), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(frame_done), 0);
        chk("arst_stall", 32'(stall_cnt), 0);
        chk("arst_ready", 32'(s_ready), 0);
        prev_acc = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #3 rst_geral_n = 1'b1;
        @(posedge clk);
        #1;
        w0 = wr_cnt;
        step(1);
        chk("rearm_busy", 32'(busy), 0);
        chk("rearm_ready", 32'(s_ready), 0);
        step(3);
        chk("rearm_wr", 32'(wr_cnt - w0), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
